// File: rtl/footies_pkg.sv
// Shared encodings for the fighting-game core: character states, resolver FSM states, winner codes.
package footies_pkg;

    typedef enum logic [2:0] {
        CHAR_IDLE    = 3'b000,
        CHAR_MOVE    = 3'b001,
        CHAR_ATTACK  = 3'b010,
        CHAR_BLOCK   = 3'b011,
        CHAR_HITSTUN = 3'b100
    } char_state_t;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'b00,
        RS_FIGHT = 2'b01,
        RS_KO    = 2'b10
    } res_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

endpackage

// File: rtl/hit_resolver_if.sv
// Game-logic side of the hit resolver: frame strobe, round control, hitbox levels and results.
interface hit_resolver_if;
    logic       tick;
    logic       round_start;
    logic       hit1_lands;
    logic       hit2_lands;
    logic [2:0] char1_state;
    logic [2:0] char2_state;
    logic [3:0] p1_health;
    logic [3:0] p2_health;
    logic       p1_stun;
    logic       p2_stun;
    logic       hit1_ack;
    logic       hit2_ack;
    logic       round_over;
    logic [1:0] winner;

    modport slave (
        input  tick, round_start, hit1_lands, hit2_lands, char1_state, char2_state,
        output p1_health, p2_health, p1_stun, p2_stun, hit1_ack, hit2_ack, round_over, winner
    );

    modport master (
        output tick, round_start, hit1_lands, hit2_lands, char1_state, char2_state,
        input  p1_health, p2_health, p1_stun, p2_stun, hit1_ack, hit2_ack, round_over, winner
    );
endinterface

// File: rtl/stun_timer.sv
// Per-player hitstun down-counter: load wins over tick, clear wins over both; 1-clk latency, no backpressure.
module stun_timer #(
    parameter logic [7:0] LOAD_VAL = 8'd12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic       i_tick,
    output logic [7:0] o_count,
    output logic       o_active
);
    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_tick && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_count  = r_count;
    assign o_active = (r_count != 8'd0);
endmodule

// File: rtl/hit_resolver.sv
// Scores hits between two players, tracks health/hitstun and the IDLE/FIGHT/KO round FSM; results 1 clk after the hit.
// No backpressure; define HIT_TRADE_EN to let simultaneous hits trade instead of clashing.
module hit_resolver
    import footies_pkg::*;
#(
    parameter int MAX_HEALTH  = 3,
    parameter int STUN_FRAMES = 12
) (
    input  logic          clk,
    input  logic          rst,
    hit_resolver_if.slave bus
);
    localparam logic [3:0] HP_INIT   = 4'(MAX_HEALTH);
    localparam logic [7:0] STUN_INIT = 8'(STUN_FRAMES);

    res_state_t r_state, w_state_nxt;
    logic [3:0] r_p1_health, r_p2_health, w_p1_health_nxt, w_p2_health_nxt;
    logic       r_used1, r_used2, w_used1_nxt, w_used2_nxt;
    logic       r_ack1, r_ack2;
    logic [1:0] r_winner, w_winner_nxt;
    logic       w_cand1, w_cand2, w_reg1, w_reg2, w_enter_fight;
    logic       w_p1_stun, w_p2_stun;
    logic [7:0] w_p1_cnt, w_p2_cnt;

    // P1's timer is loaded by P2's hits and vice versa
    stun_timer #(.LOAD_VAL(STUN_INIT)) u_p1_stun (
        .clk(clk), .rst(rst), .i_clr(w_enter_fight), .i_load(w_reg2), .i_tick(bus.tick),
        .o_count(w_p1_cnt), .o_active(w_p1_stun)
    );

    stun_timer #(.LOAD_VAL(STUN_INIT)) u_p2_stun (
        .clk(clk), .rst(rst), .i_clr(w_enter_fight), .i_load(w_reg1), .i_tick(bus.tick),
        .o_count(w_p2_cnt), .o_active(w_p2_stun)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_p1_health_nxt = r_p1_health;
        w_p2_health_nxt = r_p2_health;
        w_used1_nxt     = r_used1;
        w_used2_nxt     = r_used2;
        w_winner_nxt    = r_winner;
        w_enter_fight   = 1'b0;

        w_cand1 = (r_state == RS_FIGHT) && bus.hit1_lands && (bus.char1_state == CHAR_ATTACK)
                  && !r_used1 && (w_p2_cnt == 8'd0);
        w_cand2 = (r_state == RS_FIGHT) && bus.hit2_lands && (bus.char2_state == CHAR_ATTACK)
                  && !r_used2 && (w_p1_cnt == 8'd0);
`ifdef HIT_TRADE_EN
        w_reg1 = w_cand1;
        w_reg2 = w_cand2;
`else
        w_reg1 = w_cand1 && !w_cand2;
        w_reg2 = w_cand2 && !w_cand1;
`endif

        // A clash still burns both attacks, so the flag follows the candidate, not the registered hit
        if (bus.char1_state != CHAR_ATTACK) w_used1_nxt = 1'b0;
        else if (w_cand1)                   w_used1_nxt = 1'b1;
        if (bus.char2_state != CHAR_ATTACK) w_used2_nxt = 1'b0;
        else if (w_cand2)                   w_used2_nxt = 1'b1;

        case (r_state)
            RS_IDLE, RS_KO: begin
                if (bus.round_start) begin
                    w_state_nxt     = RS_FIGHT;
                    w_enter_fight   = 1'b1;
                    w_p1_health_nxt = HP_INIT;
                    w_p2_health_nxt = HP_INIT;
                    w_used1_nxt     = 1'b0;
                    w_used2_nxt     = 1'b0;
                    w_winner_nxt    = WIN_NONE;
                end
            end
            RS_FIGHT: begin
                if (w_reg2) w_p1_health_nxt = sat_dec(r_p1_health);
                if (w_reg1) w_p2_health_nxt = sat_dec(r_p2_health);
                if ((w_p1_health_nxt == 4'd0) || (w_p2_health_nxt == 4'd0)) begin
                    w_state_nxt = RS_KO;
                    if ((w_p1_health_nxt == 4'd0) && (w_p2_health_nxt == 4'd0)) w_winner_nxt = WIN_DRAW;
                    else if (w_p1_health_nxt == 4'd0)                           w_winner_nxt = WIN_P2;
                    else                                                        w_winner_nxt = WIN_P1;
                end
            end
            default: w_state_nxt = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_health <= HP_INIT;
            r_p2_health <= HP_INIT;
            r_used1     <= 1'b0;
            r_used2     <= 1'b0;
            r_ack1      <= 1'b0;
            r_ack2      <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_p1_health <= w_p1_health_nxt;
            r_p2_health <= w_p2_health_nxt;
            r_used1     <= w_used1_nxt;
            r_used2     <= w_used2_nxt;
            r_ack1      <= w_reg1;
            r_ack2      <= w_reg2;
            r_winner    <= w_winner_nxt;
        end
    end

    assign bus.p1_health  = r_p1_health;
    assign bus.p2_health  = r_p2_health;
    assign bus.p1_stun    = w_p1_stun;
    assign bus.p2_stun    = w_p2_stun;
    assign bus.hit1_ack   = r_ack1;
    assign bus.hit2_ack   = r_ack2;
    assign bus.round_over = (r_state == RS_KO);
    assign bus.winner     = r_winner;
endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 Parameter MAX_HEALTH, default 3, health points each player starts a round with (1..15).
REQ-002 Parameter STUN_FRAMES, default 12, hitstun length in frame ticks (1..255).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-clk frame strobe (60 Hz), advances stun timers.
REQ-006 round_start  input  1  one-clk pulse; starts a round.
REQ-007 hit1_lands  input  1  level: P1 attack hitbox overlaps P2.
REQ-008 hit2_lands  input  1  level: P2 attack hitbox overlaps P1.
REQ-009 char1_state  input  3  P1 FSM state; ATTACK = 3'b010.
REQ-010 char2_state  input  3  P2 FSM state; ATTACK = 3'b010.
REQ-011 p1_health  output  4  P1 remaining health.
REQ-012 p2_health  output  4  P2 remaining health.
REQ-013 p1_stun  output  1  high while P1 is in hitstun.
REQ-014 p2_stun  output  1  high while P2 is in hitstun.
REQ-015 hit1_ack  output  1  one-clk pulse: P1 hit registered on P2.
REQ-016 hit2_ack  output  1  one-clk pulse: P2 hit registered on P1.
REQ-017 round_over  output  1  high in KO state.
REQ-018 winner  output  2  00 none, 01 P1, 10 P2, 11 draw; valid while round_over.

Function
REQ-019 FSM states IDLE, FIGHT, KO; IDLE->FIGHT on round_start; FIGHT->KO when either health reaches 0; KO->FIGHT on round_start; no other transitions.
REQ-020 On any transition into FIGHT, both healths reload MAX_HEALTH, stun timers and attack-used flags clear, winner becomes 00.
REQ-021 Hit candidate P1 in FIGHT: hit1_lands high AND char1_state==ATTACK AND P1 attack-used flag clear AND p2_stun low; P2 symmetric.
REQ-022 A registered hit sets the attacker's attack-used flag; flag clears in the first cycle the attacker's state is not ATTACK, so one attack scores at most once.
REQ-023 Registered hit: defender health decrements by 1 (saturating at 0), defender stun timer loads STUN_FRAMES, ack pulses; all visible the clock after the candidate cycle (latency 1).
REQ-024 Stun timer decrements by 1 on each tick while nonzero; stun output high iff timer nonzero; a load and tick in the same cycle load STUN_FRAMES.
REQ-025 Candidates are ignored in IDLE and KO; acks stay low; healths frozen.
REQ-026 Simultaneous candidates for both players: handled per REQ-031/REQ-032.
REQ-027 KO entry: winner 01 if only p2_health==0, 10 if only p1_health==0, 11 if both 0; round_over high from the same clock that the zero health is visible.
REQ-028 round_start arriving in FIGHT is ignored.

Reset
REQ-029 rst asynchronously forces IDLE, p1_health=p2_health=MAX_HEALTH, stun timers 0, attack-used flags 0, hit1_ack=hit2_ack=0, round_over=0, winner=00.
REQ-030 Reset mid-round or mid-stun discards all round state; no ack pulse is emitted on reset release.

Configuration
REQ-031 With HIT_TRADE_EN defined, simultaneous candidates both register (trade): both healths decrement, both stun, both acks pulse, both attack-used flags set.
REQ-032 Without HIT_TRADE_EN, simultaneous candidates clash: neither registers, no health change, no acks, but both attack-used flags set.

Structure
REQ-033 Shared package footies_pkg holds character state encodings (incl. ATTACK=3'b010), resolver FSM state encodings and winner codes; resolver imports them.
REQ-034 One sub-module stun_timer (load, tick, count, active output, width 8) instantiated once per player.

Verification
REQ-035 Reset, round_start, hit1_lands+char1_state=ATTACK held 20 clk -> exactly one hit1_ack, p2_health 3->2, p2_stun high for 12 ticks.
REQ-036 P1 attacks, leaves ATTACK, attacks again after p2_stun drops -> second hit1_ack, p2_health 1; attack during p2_stun -> no ack.
REQ-037 Both candidates same clk, healths 3/3 -> with HIT_TRADE_EN 2/2 and both acks; without, 3/3 and no acks.
REQ-038 Three P2 hits -> p1_health 0, round_over=1, winner=10; further hits ignored; round_start -> health 3/3, winner 00.
REQ-039 Trade at healths 1/1 with HIT_TRADE_EN -> both 0, winner=11.
REQ-040 rst asserted with p2_stun active and health 1/2 -> immediate IDLE, health 3/3, stun low, no ack after release.
